// File: rtl/alpharetz_uart_rx_if.sv
// CPU-side receive port of alpharetz_uart_rx: received word, error flags and the ack handshake.
// The receiver drives the word (master); the CPU consumes it and acks (slave).
interface alpharetz_uart_rx_if #(
  parameter int unsigned UART_DATA_WIDTH = 8
) ();

  logic                       rx_ack;
  logic [UART_DATA_WIDTH-1:0] rx_data;
  logic                       rx_valid;
  logic                       parity_err;
  logic                       frame_err;
  logic                       overrun;
  logic                       busy;

  modport master (
    input  rx_ack,
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    output overrun,
    output busy
  );

  modport slave (
    output rx_ack,
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    input  overrun,
    input  busy
  );

endinterface

// File: rtl/alpharetz_uart_rx.sv
// UART receiver: start bit, UART_DATA_WIDTH data bits LSB first, even parity, one stop bit.
// Oversampled by the sys_clk_en tick; words are handed to the CPU with valid/ack and error flags.
module alpharetz_uart_rx #(
  parameter int unsigned UART_DATA_WIDTH = 8,
  parameter int unsigned UART_CLK_RATIO  = 16
) (
  input  logic                sys_clk,
  input  logic                sync_rst,
  input  logic                sys_clk_en,
  input  logic                uart_rx,
  alpharetz_uart_rx_if.master cpu_if
);

  localparam int unsigned TickW = $clog2(UART_CLK_RATIO);
  localparam int unsigned BitW  = $clog2(UART_DATA_WIDTH) + 1;

  localparam logic [TickW-1:0] HalfLast = TickW'(UART_CLK_RATIO / 2 - 1);
  localparam logic [TickW-1:0] FullLast = TickW'(UART_CLK_RATIO - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(UART_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 sync_q, sync_d;
  logic [TickW-1:0]           tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                       par_mis_q, par_mis_d;
  logic [UART_DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                       rx_valid_q, rx_valid_d;
  logic                       parity_err_q, parity_err_d;
  logic                       frame_err_q, frame_err_d;
  logic                       overrun_q, overrun_d;

  logic                       rx_s;
  logic                       commit;
  logic [UART_DATA_WIDTH:0]   shift_ext;

  // Two-flop synchronizer, ungated so the line is tracked even while ticks are stalled.
  assign sync_d    = {sync_q[0], uart_rx};
  assign rx_s      = sync_q[1];
  assign shift_ext = {rx_s, shift_q};

  // Tick counters count the ticks already elapsed since the last sample point, so the
  // sample fires when the counter reaches one less than the interval.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_mis_d  = par_mis_q;
    commit     = 1'b0;

    if (sys_clk_en) begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_d    = StStart;
            tick_cnt_d = '0;
          end
        end

        StStart: begin
          if (tick_cnt_q == HalfLast) begin
            if (!rx_s) begin
              state_d    = StData;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end

        StData: begin
          if (tick_cnt_q == FullLast) begin
            tick_cnt_d = '0;
            shift_d    = shift_ext[UART_DATA_WIDTH:1];
            bit_cnt_d  = bit_cnt_q + BitW'(1);
            if (bit_cnt_q == BitLast) begin
              state_d = StParity;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end

        StParity: begin
          if (tick_cnt_q == FullLast) begin
            tick_cnt_d = '0;
            par_mis_d  = rx_s ^ (^shift_q);
            state_d    = StStop;
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end

        StStop: begin
          if (tick_cnt_q == FullLast) begin
            tick_cnt_d = '0;
            commit     = 1'b1;
            state_d    = StIdle;
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end

        default: begin
          state_d    = StIdle;
          tick_cnt_d = '0;
        end
      endcase
    end
  end

  // Ack is handled every cycle; a commit in the same cycle overrides it.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;

    if (cpu_if.rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    if (commit) begin
      rx_data_d    = shift_q;
      parity_err_d = par_mis_q;
      frame_err_d  = !rx_s;
      rx_valid_d   = 1'b1;
      if (rx_valid_q && !cpu_if.rx_ack) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      state_q      <= StIdle;
      sync_q       <= 2'b11;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_mis_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_mis_q    <= par_mis_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign cpu_if.rx_data    = rx_data_q;
  assign cpu_if.rx_valid   = rx_valid_q;
  assign cpu_if.parity_err = parity_err_q;
  assign cpu_if.frame_err  = frame_err_q;
  assign cpu_if.overrun    = overrun_q;
  assign cpu_if.busy       = (state_q != StIdle);

endmodule
